// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, horizontal/vertical scan counters and
// registered sync/active/coordinate/pulse outputs that all describe the same position.
module vga_timing_gen #(
  parameter int CLK_DIV          = 4,
  parameter int H_SYNC           = 96,
  parameter int H_BACK           = 48,
  parameter int H_ACTIVE         = 640,
  parameter int H_FRONT          = 16,
  parameter int V_SYNC           = 2,
  parameter int V_BACK           = 33,
  parameter int V_ACTIVE         = 480,
  parameter int V_FRONT          = 10,
  parameter int SYNC_ACTIVE_HIGH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       pix_tick,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [4:0]  DIV_LAST  = 5'(CLK_DIV - 1);
  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_SYNC_W  = 11'(H_SYNC);
  localparam logic [10:0] V_SYNC_W  = 11'(V_SYNC);
  localparam logic [10:0] H_ACT_LO  = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_ACT_HI  = 11'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [10:0] V_ACT_LO  = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_ACT_HI  = 11'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [9:0]  H_OFS     = 10'(H_SYNC + H_BACK);
  localparam logic [9:0]  V_OFS     = 10'(V_SYNC + V_BACK);
  localparam logic        SYNC_ON   = (SYNC_ACTIVE_HIGH != 0);

  logic [4:0] div_q, div_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       started_q, started_d;
  logic       pix_tick_q, pix_tick_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       active_q, active_d;
  logic [9:0] pix_x_q, pix_x_d;
  logic [9:0] pix_y_q, pix_y_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic       adv;
  logic       h_in, v_in;

  always_comb begin
    div_d         = div_q;
    h_d           = h_q;
    v_d           = v_q;
    started_d     = started_q;
    pix_tick_d    = 1'b0;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    active_d      = active_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    adv           = 1'b0;
    h_in          = 1'b0;
    v_in          = 1'b0;

    if (en) begin
      started_d = 1'b1;
      if (!started_q) begin
        // First enabled clock after reset presents (0,0) without advancing.
        div_d         = 5'd0;
        h_d           = 10'd0;
        v_d           = 10'd0;
        line_start_d  = 1'b1;
        frame_start_d = 1'b1;
      end else begin
        // The clock that displayed the tick is followed by the pixel advance.
        adv   = (div_q == DIV_LAST);
        div_d = adv ? 5'd0 : 5'(div_q + 5'd1);
        if (adv) begin
          if (h_q == H_LAST) begin
            h_d = 10'd0;
            v_d = (v_q == V_LAST) ? 10'd0 : 10'(v_q + 10'd1);
          end else begin
            h_d = 10'(h_q + 10'd1);
          end
        end
        line_start_d  = adv && (h_d == 10'd0);
        frame_start_d = adv && (h_d == 10'd0) && (v_d == 10'd0);
      end

      pix_tick_d = (div_d == DIV_LAST);
      hsync_d    = ({1'b0, h_d} < H_SYNC_W) ? SYNC_ON : ~SYNC_ON;
      vsync_d    = ({1'b0, v_d} < V_SYNC_W) ? SYNC_ON : ~SYNC_ON;
      h_in       = ({1'b0, h_d} >= H_ACT_LO) && ({1'b0, h_d} < H_ACT_HI);
      v_in       = ({1'b0, v_d} >= V_ACT_LO) && ({1'b0, v_d} < V_ACT_HI);
      active_d   = h_in && v_in;
      pix_x_d    = active_d ? 10'(h_d - H_OFS) : 10'd0;
      pix_y_d    = active_d ? 10'(v_d - V_OFS) : 10'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q         <= 5'd0;
      h_q           <= 10'd0;
      v_q           <= 10'd0;
      started_q     <= 1'b0;
      pix_tick_q    <= 1'b0;
      hsync_q       <= ~SYNC_ON;
      vsync_q       <= ~SYNC_ON;
      active_q      <= 1'b0;
      pix_x_q       <= 10'd0;
      pix_y_q       <= 10'd0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      started_q     <= started_d;
      pix_tick_q    <= pix_tick_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_tick    = pix_tick_q;
  assign hcount      = h_q;
  assign vcount      = v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
